// File: rtl/jtag_pkg.sv
// Shared JTAG TAP types: 1149.1 state encoding, opcode constants, DR select.
package jtag_pkg;

    localparam int unsigned TAP_STATE_W = 4;

    typedef enum logic [TAP_STATE_W-1:0] {
        TAP_EXIT2_DR         = 4'h0,
        TAP_EXIT1_DR         = 4'h1,
        TAP_SHIFT_DR         = 4'h2,
        TAP_PAUSE_DR         = 4'h3,
        TAP_SELECT_IR        = 4'h4,
        TAP_UPDATE_DR        = 4'h5,
        TAP_CAPTURE_DR       = 4'h6,
        TAP_SELECT_DR        = 4'h7,
        TAP_EXIT2_IR         = 4'h8,
        TAP_EXIT1_IR         = 4'h9,
        TAP_SHIFT_IR         = 4'hA,
        TAP_PAUSE_IR         = 4'hB,
        TAP_RUN_TEST_IDLE    = 4'hC,
        TAP_UPDATE_IR        = 4'hD,
        TAP_CAPTURE_IR       = 4'hE,
        TAP_TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    // Opcodes are truncated to the instruction width at the point of use.
    localparam int unsigned JTAG_OP_IDCODE = 1;
    localparam int unsigned JTAG_OP_USER   = 2;
    localparam logic [31:0] JTAG_OP_BYPASS = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller state register, advanced only on a synchronized tck rise.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rise_i,
    input  logic       tms_i,
    output tap_state_t state_o
);

    tap_state_t state_q;
    tap_state_t state_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= TAP_TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rise_i) begin
            unique case (state_q)
                TAP_TEST_LOGIC_RESET: state_d = tms_i ? TAP_TEST_LOGIC_RESET : TAP_RUN_TEST_IDLE;
                TAP_RUN_TEST_IDLE:    state_d = tms_i ? TAP_SELECT_DR : TAP_RUN_TEST_IDLE;
                TAP_SELECT_DR:        state_d = tms_i ? TAP_SELECT_IR : TAP_CAPTURE_DR;
                TAP_CAPTURE_DR:       state_d = tms_i ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
                TAP_SHIFT_DR:         state_d = tms_i ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
                TAP_EXIT1_DR:         state_d = tms_i ? TAP_UPDATE_DR : TAP_PAUSE_DR;
                TAP_PAUSE_DR:         state_d = tms_i ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
                TAP_EXIT2_DR:         state_d = tms_i ? TAP_UPDATE_DR : TAP_SHIFT_DR;
                TAP_UPDATE_DR:        state_d = tms_i ? TAP_SELECT_DR : TAP_RUN_TEST_IDLE;
                TAP_SELECT_IR:        state_d = tms_i ? TAP_TEST_LOGIC_RESET : TAP_CAPTURE_IR;
                TAP_CAPTURE_IR:       state_d = tms_i ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
                TAP_SHIFT_IR:         state_d = tms_i ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
                TAP_EXIT1_IR:         state_d = tms_i ? TAP_UPDATE_IR : TAP_PAUSE_IR;
                TAP_PAUSE_IR:         state_d = tms_i ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
                TAP_EXIT2_IR:         state_d = tms_i ? TAP_UPDATE_IR : TAP_SHIFT_IR;
                TAP_UPDATE_IR:        state_d = tms_i ? TAP_SELECT_DR : TAP_RUN_TEST_IDLE;
                default:              state_d = TAP_TEST_LOGIC_RESET;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_responder.sv
// Device-side JTAG TAP in the sys_clk domain: IDCODE, BYPASS and optional USER DR.
// Optional user data register enabled by defining JTAG_TAP_USER_DR_EN.
module jtag_tap_responder
    import jtag_pkg::*;
#(
    parameter int unsigned IR_WIDTH      = 5,
    parameter logic [31:0] IDCODE        = 32'h1000_0001,
    parameter int unsigned USER_DR_WIDTH = 32
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     tck,
    input  logic                     tms,
    input  logic                     tdi,
    output logic                     tdo,
    output tap_state_t               tap_state,
    output logic [IR_WIDTH-1:0]      ir,
    input  logic [USER_DR_WIDTH-1:0] user_capture_data,
    output logic [USER_DR_WIDTH-1:0] user_update_data,
    output logic                     user_update_valid
);

    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(JTAG_OP_IDCODE);
    localparam logic [IR_WIDTH-1:0] OP_BYPASS = IR_WIDTH'(JTAG_OP_BYPASS);

    // tck/tms/tdi travel together so tms/tdi are aligned with the detected edge
    logic [2:0] sync1_q, sync2_q;
    logic       tck_d_q;
    logic       tck_s, tms_s, tdi_s, rise_c, fall_c;

    assign {tck_s, tms_s, tdi_s} = sync2_q;
    assign rise_c = tck_s & ~tck_d_q;
    assign fall_c = ~tck_s & tck_d_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            tck_d_q <= 1'b0;
        end else begin
            sync1_q <= {tck, tms, tdi};
            sync2_q <= sync1_q;
            tck_d_q <= tck_s;
        end
    end

    jtag_tap_fsm u_fsm (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .rise_i  (rise_c),
        .tms_i   (tms_s),
        .state_o (tap_state)
    );

    logic [IR_WIDTH-1:0] ir_q, ir_d, ir_sr_q, ir_sr_d;
    logic [31:0]         id_sr_q, id_sr_d;
    logic                byp_q, byp_d, tdo_q, tdo_d;
    dr_sel_t             dr_sel_c;
    logic                dr_lsb_c;
`ifdef JTAG_TAP_USER_DR_EN
    localparam logic [IR_WIDTH-1:0] OP_USER = IR_WIDTH'(JTAG_OP_USER);
    logic [USER_DR_WIDTH-1:0] usr_sr_q, usr_sr_d, upd_data_q, upd_data_d;
    logic                     upd_valid_q, upd_valid_d;
`endif

    // Instruction decode: unknown opcodes fall through to BYPASS
    always_comb begin
        dr_sel_c = DR_BYPASS;
        if (ir_q == OP_BYPASS) begin
            dr_sel_c = DR_BYPASS;
        end else if (ir_q == OP_IDCODE) begin
            dr_sel_c = DR_IDCODE;
`ifdef JTAG_TAP_USER_DR_EN
        end else if (ir_q == OP_USER) begin
            dr_sel_c = DR_USER;
`endif
        end
    end

    always_comb begin
        case (dr_sel_c)
            DR_IDCODE: dr_lsb_c = id_sr_q[0];
`ifdef JTAG_TAP_USER_DR_EN
            DR_USER:   dr_lsb_c = usr_sr_q[0];
`endif
            default:   dr_lsb_c = byp_q;
        endcase
    end

    always_comb begin
        ir_d    = ir_q;
        ir_sr_d = ir_sr_q;
        id_sr_d = id_sr_q;
        byp_d   = byp_q;
        tdo_d   = tdo_q;
`ifdef JTAG_TAP_USER_DR_EN
        usr_sr_d    = usr_sr_q;
        upd_data_d  = upd_data_q;
        upd_valid_d = 1'b0;
`endif
        if (rise_c) begin
            unique case (tap_state)
                TAP_CAPTURE_IR: ir_sr_d = IR_WIDTH'(1);
                TAP_SHIFT_IR:   ir_sr_d = {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
                TAP_UPDATE_IR:  ir_d    = ir_sr_q;
                TAP_CAPTURE_DR: begin
                    case (dr_sel_c)
                        DR_IDCODE: id_sr_d  = IDCODE;
`ifdef JTAG_TAP_USER_DR_EN
                        DR_USER:   usr_sr_d = user_capture_data;
`endif
                        default:   byp_d    = 1'b0;
                    endcase
                end
                TAP_SHIFT_DR: begin
                    case (dr_sel_c)
                        DR_IDCODE: id_sr_d  = {tdi_s, id_sr_q[31:1]};
`ifdef JTAG_TAP_USER_DR_EN
                        DR_USER:   usr_sr_d = {tdi_s, usr_sr_q[USER_DR_WIDTH-1:1]};
`endif
                        default:   byp_d    = tdi_s;
                    endcase
                end
`ifdef JTAG_TAP_USER_DR_EN
                TAP_UPDATE_DR: begin
                    if (dr_sel_c == DR_USER) begin
                        upd_data_d  = usr_sr_q;
                        upd_valid_d = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
        if (fall_c) begin
            tdo_d = 1'b0;
            if (tap_state == TAP_SHIFT_IR) begin
                tdo_d = ir_sr_q[0];
            end else if (tap_state == TAP_SHIFT_DR) begin
                tdo_d = dr_lsb_c;
            end
        end
        if (tap_state == TAP_TEST_LOGIC_RESET) begin
            ir_d = OP_IDCODE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ir_q    <= OP_IDCODE;
            ir_sr_q <= '0;
            id_sr_q <= '0;
            byp_q   <= 1'b0;
            tdo_q   <= 1'b0;
`ifdef JTAG_TAP_USER_DR_EN
            usr_sr_q    <= '0;
            upd_data_q  <= '0;
            upd_valid_q <= 1'b0;
`endif
        end else begin
            ir_q    <= ir_d;
            ir_sr_q <= ir_sr_d;
            id_sr_q <= id_sr_d;
            byp_q   <= byp_d;
            tdo_q   <= tdo_d;
`ifdef JTAG_TAP_USER_DR_EN
            usr_sr_q    <= usr_sr_d;
            upd_data_q  <= upd_data_d;
            upd_valid_q <= upd_valid_d;
`endif
        end
    end

    assign tdo = tdo_q;
    assign ir  = ir_q;
`ifdef JTAG_TAP_USER_DR_EN
    assign user_update_data  = upd_data_q;
    assign user_update_valid = upd_valid_q;
`else
    logic unused_user_capture;
    assign unused_user_capture = ^user_capture_data;
    assign user_update_data    = '0;
    assign user_update_valid   = 1'b0;
`endif

endmodule
